// File: rtl/rbus_frame_buffer_if.sv
// Frame bus between a producer, the frame buffer and a downstream consumer.
// The buffer connects through the slave modport; a driver or bench uses master.
interface rbus_frame_buffer_if;
  logic        i_stb;
  logic        i_sof;
  logic [71:0] i_data;
  logic [1:0]  i_rdy;
  logic [1:0]  i_rdyE;
  logic        o_stb;
  logic        o_sof;
  logic [71:0] o_data;
  logic [1:0]  o_rdy;
  logic [1:0]  o_rdyE;
  logic        ff_err;

  modport slave (
    input  i_stb, i_sof, i_data, o_rdy, o_rdyE,
    output i_rdy, i_rdyE, o_stb, o_sof, o_data, ff_err
  );

  modport master (
    output i_stb, i_sof, i_data, o_rdy, o_rdyE,
    input  i_rdy, i_rdyE, o_stb, o_sof, o_data, ff_err
  );
endinterface

// File: rtl/rbus_frame_buffer.sv
// Two-class store-and-forward frame buffer. Each class has its own FIFO.
// A frame is released only once its last word is stored, and class 1 wins
// arbitration over class 0.
// Every stored word carries a "last" flag. The reader stops on that flag,
// so a frame that was closed early on a protocol error still drains cleanly.
//
//   state  | meaning
//   IDLE   | waiting for a complete frame whose consumer is ready
//   SEND   | streaming the latched class's frame, one word per cycle
module rbus_frame_buffer #(
  parameter int DEPTH  = 32,
  parameter int MAXLEN = 16
) (
  input logic                clk,
  input logic                rst,
  rbus_frame_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [71:0]      mem_q    [2][DEPTH];
  logic [DEPTH-1:0] last_q   [2];
  logic [AW-1:0]    wr_ptr_q [2];
  logic [AW-1:0]    rd_ptr_q [2];
  logic [CW-1:0]    occ_q [2], occ_d [2];
  logic [CW-1:0]    fcnt_q[2], fcnt_d[2];
  logic [3:0]       rem_q, rem_d;
  logic             cls_q, cls_d;
  logic             err_q;
  logic [1:0]       i_rdy_q, i_rdyE_q;
  logic [1:0]       full;

  logic             wr_en, wr_cls, done_wr, close, err;
  logic [AW-1:0]    wr_prev;

  logic [0:0]       state_q;
  logic             sel_q, last_sent_q;
  logic             o_stb_q, o_sof_q;
  logic [71:0]      o_data_q;
  logic             go, pick, rd_cls, rd_en, rd_last;
  logic [71:0]      rd_word;
  logic             unused_rdy_e;

  assign unused_rdy_e = ^bus.o_rdyE;
  assign full[0]      = occ_q[0] == CW'(DEPTH);
  assign full[1]      = occ_q[1] == CW'(DEPTH);
  assign wr_prev      = wr_ptr_q[cls_q] - AW'(1);

  // Input framing. An early close marks the previous stored word as last.
  always_comb begin
    wr_en   = 1'b0;
    wr_cls  = cls_q;
    done_wr = 1'b0;
    close   = 1'b0;
    err     = 1'b0;
    rem_d   = rem_q;
    cls_d   = cls_q;
    if (bus.i_stb) begin
      if (bus.i_sof) begin
        if (rem_q != 4'd0) begin
          err   = 1'b1;
          close = 1'b1;
          rem_d = 4'd0;
        end else if (full[bus.i_data[71]]) begin
          err = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_cls  = bus.i_data[71];
          cls_d   = bus.i_data[71];
          rem_d   = bus.i_data[70:67];
          done_wr = bus.i_data[70:67] == 4'd0;
        end
      end else if (rem_q == 4'd0) begin
        err = 1'b1;
      end else begin
        rem_d = rem_q - 4'd1;
        if (full[cls_q]) begin
          err   = 1'b1;
          close = rem_q == 4'd1;
        end else begin
          wr_en   = 1'b1;
          done_wr = rem_q == 4'd1;
        end
      end
    end else if (rem_q != 4'd0) begin
      err   = 1'b1;
      close = 1'b1;
      rem_d = 4'd0;
    end
  end

  // Output arbitration and read-port selection.
  always_comb begin
    pick    = (fcnt_q[1] != '0) && bus.o_rdy[1];
    go      = pick || ((fcnt_q[0] != '0) && bus.o_rdy[0]);
    rd_cls  = (state_q == S_IDLE) ? pick : sel_q;
    rd_en   = (state_q == S_IDLE) ? go : !last_sent_q;
    rd_word = mem_q[rd_cls][rd_ptr_q[rd_cls]];
    rd_last = last_q[rd_cls][rd_ptr_q[rd_cls]];
  end

  // Per-class occupancy and complete-frame counts after this cycle's write and read.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      occ_d[c]  = occ_q[c] + CW'(wr_en && (wr_cls == 1'(c)))
                           - CW'(rd_en && (rd_cls == 1'(c)));
      fcnt_d[c] = fcnt_q[c]
                + CW'((wr_en && done_wr && (wr_cls == 1'(c))) || (close && (cls_q == 1'(c))))
                - CW'((state_q == S_SEND) && last_sent_q && (sel_q == 1'(c)));
    end
  end

  // Word storage. Unreset, because pointers and counts gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_cls][wr_ptr_q[wr_cls]]  <= bus.i_data;
      last_q[wr_cls][wr_ptr_q[wr_cls]] <= done_wr;
    end
    if (close) last_q[cls_q][wr_prev] <= 1'b1;
  end

  // Write-side state: frame tracking, pointers, counts, ready flags and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q    <= 4'd0;
      cls_q    <= 1'b0;
      err_q    <= 1'b0;
      i_rdy_q  <= 2'b11;
      i_rdyE_q <= 2'b11;
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        occ_q[c]    <= '0;
        fcnt_q[c]   <= '0;
      end
    end else begin
      rem_q <= rem_d;
      cls_q <= cls_d;
      err_q <= err_q | err;
      if (wr_en) wr_ptr_q[wr_cls] <= wr_ptr_q[wr_cls] + AW'(1);
      for (int c = 0; c < 2; c++) begin
        occ_q[c]    <= occ_d[c];
        fcnt_q[c]   <= fcnt_d[c];
        i_rdy_q[c]  <= (CW'(DEPTH) - occ_d[c]) >= CW'(MAXLEN);
        i_rdyE_q[c] <= occ_d[c] == '0;
      end
    end
  end

  // Output FSM. The word after the last one is always idle, which keeps a gap between frames.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      last_sent_q <= 1'b0;
      o_stb_q     <= 1'b0;
      o_sof_q     <= 1'b0;
      o_data_q    <= '0;
      rd_ptr_q[0] <= '0;
      rd_ptr_q[1] <= '0;
    end else begin
      if (rd_en) rd_ptr_q[rd_cls] <= rd_ptr_q[rd_cls] + AW'(1);
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q     <= S_SEND;
            sel_q       <= pick;
            o_stb_q     <= 1'b1;
            o_sof_q     <= 1'b1;
            o_data_q    <= rd_word;
            last_sent_q <= rd_last;
          end else begin
            o_stb_q <= 1'b0;
            o_sof_q <= 1'b0;
          end
        end
        S_SEND: begin
          o_sof_q <= 1'b0;
          if (last_sent_q) begin
            o_stb_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            o_stb_q     <= 1'b1;
            o_data_q    <= rd_word;
            last_sent_q <= rd_last;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.i_rdy  = i_rdy_q;
  assign bus.i_rdyE = i_rdyE_q;
  assign bus.o_stb  = o_stb_q;
  assign bus.o_sof  = o_sof_q;
  assign bus.o_data = o_data_q;
  assign bus.ff_err = err_q;
endmodule

// File: tb/tb_rbus_frame_buffer.sv
// Bench for rbus_frame_buffer. Expected output is a queue of words per class,
// filled as frames are written. The monitor pops a word from that queue for
// each output word, and also checks framing, inter-frame gaps and data hold.
module tb_rbus_frame_buffer;
  logic clk;
  logic rst;
  rbus_frame_buffer_if bus();

  rbus_frame_buffer #(.DEPTH(32), .MAXLEN(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [72:0] exp0_q[$];
  logic [72:0] exp1_q[$];
  int          out_cls_q[$];
  bit          rand_mode = 0;

  task automatic chk(input string tag, input logic [72:0] act, input logic [72:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Output monitor
  logic        prev_stb = 1'b0;
  logic [71:0] last_data = '0;
  logic        cur_cls = 1'b0;
  always @(negedge clk) begin
    logic [72:0] e;
    bit avail;
    if (!rst) begin
      prev_stb  = 1'b0;
      last_data = '0;
    end else begin
      if (bus.o_stb) begin
        if (bus.o_sof) begin
          chk("idle_gap", {72'd0, prev_stb}, 73'd0);
          cur_cls = bus.o_data[71];
          out_cls_q.push_back(int'(cur_cls));
        end else begin
          chk("no_gap", {72'd0, prev_stb}, 73'd1);
        end
        avail = cur_cls ? (exp1_q.size() != 0) : (exp0_q.size() != 0);
        chk("word_expected", {72'd0, avail}, 73'd1);
        if (avail) begin
          e = cur_cls ? exp1_q.pop_front() : exp0_q.pop_front();
          chk("out_word", {bus.o_sof, bus.o_data}, e);
        end
        last_data = bus.o_data;
      end else begin
        chk("data_hold", {1'b0, bus.o_data}, {1'b0, last_data});
      end
      prev_stb = bus.o_stb;
    end
  end

  task automatic tick();
    if (rand_mode) begin
      bus.o_rdy  = 2'($urandom_range(0, 3));
      bus.o_rdyE = 2'($urandom_range(0, 3));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.i_stb = 1'b0;
    bus.i_sof = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drive_word(input logic sof, input logic [71:0] d);
    bus.i_stb  = 1'b1;
    bus.i_sof  = sof;
    bus.i_data = d;
    tick();
    bus.i_stb = 1'b0;
    bus.i_sof = 1'b0;
  endtask

  function automatic logic [71:0] rand_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[71:0];
  endfunction

  function automatic logic [71:0] header(input logic cls, input int len);
    logic [71:0] h;
    logic [3:0]  l;
    h = rand_word();
    l = 4'(len - 1);
    h[71] = cls;
    h[70:67] = l;
    return h;
  endfunction

  task automatic expect_word(input logic cls, input logic sof, input logic [71:0] d);
    if (cls) exp1_q.push_back({sof, d});
    else     exp0_q.push_back({sof, d});
  endtask

  // Drives a frame. Stores only n_words (<= len) words; the rest become protocol errors.
  task automatic send_frame(input logic cls, input int len, input int n_words, input bit push);
    logic [71:0] w;
    for (int i = 0; i < n_words; i++) begin
      w = (i == 0) ? header(cls, len) : rand_word();
      drive_word(i == 0, w);
      if (push) expect_word(cls, i == 0, w);
    end
    bus.i_stb = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (exp0_q.size() == 0 && exp1_q.size() == 0 && !bus.o_stb) done = 1;
      else tick();
    end
    chk(tag, {72'd0, done}, 73'd1);
  endtask

  task automatic wait_rdy(input logic cls);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (bus.i_rdy[cls]) ok = 1;
      else tick();
    end
    chk("wait_i_rdy", {72'd0, ok}, 73'd1);
  endtask

  task automatic do_reset();
    bus.i_stb = 1'b0;
    bus.i_sof = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp0_q.delete();
    exp1_q.delete();
    out_cls_q.delete();
  endtask

  initial begin
    bit seen;
    int lens[5] = '{16, 16, 7, 16, 13};
    rst        = 1'b0;
    bus.i_stb  = 1'b0;
    bus.i_sof  = 1'b0;
    bus.i_data = '0;
    bus.o_rdy  = 2'b00;
    bus.o_rdyE = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset values
    chk("rst_o_stb",  {72'd0, bus.o_stb}, 73'd0);
    chk("rst_o_sof",  {72'd0, bus.o_sof}, 73'd0);
    chk("rst_o_data", {1'b0, bus.o_data}, 73'd0);
    chk("rst_ff_err", {72'd0, bus.ff_err}, 73'd0);
    chk("rst_i_rdy",  {71'd0, bus.i_rdy}, 73'd3);
    chk("rst_i_rdyE", {71'd0, bus.i_rdyE}, 73'd3);

    // Single 4-word class-0 frame, o_sof two cycles after the last write
    bus.o_rdy = 2'b01;
    send_frame(1'b0, 4, 4, 1);
    chk("lat_t1_stb", {72'd0, bus.o_stb}, 73'd0);
    idle(1);
    chk("lat_t2_sof", {72'd0, bus.o_sof}, 73'd1);
    wait_drain("drain_single");

    // Class 1 is served first, then class 0
    bus.o_rdy = 2'b00;
    out_cls_q.delete();
    send_frame(1'b0, 3, 3, 1);
    send_frame(1'b1, 5, 5, 1);
    idle(3);
    bus.o_rdy = 2'b11;
    wait_drain("drain_prio");
    chk("prio_n",      73'(out_cls_q.size()), 73'd2);
    if (out_cls_q.size() == 2) begin
      chk("prio_first",  73'(out_cls_q[0]), 73'd1);
      chk("prio_second", 73'(out_cls_q[1]), 73'd0);
    end

    // Backpressure holds a stored frame; release starts output one cycle later
    bus.o_rdy = 2'b00;
    send_frame(1'b0, 2, 2, 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      seen |= bus.o_stb;
      idle(1);
    end
    chk("bp_hold", {72'd0, seen}, 73'd0);
    bus.o_rdy = 2'b01;
    idle(1);
    chk("bp_start", {72'd0, bus.o_sof}, 73'd1);
    wait_drain("drain_bp");
    chk("no_err_yet", {72'd0, bus.ff_err}, 73'd0);

    // Fill to full, overflow, then wrap the pointers
    bus.o_rdy = 2'b00;
    send_frame(1'b0, 16, 16, 1);
    chk("half_i_rdy", {71'd0, bus.i_rdy}, 73'd3);
    send_frame(1'b0, 16, 16, 1);
    chk("full_i_rdy",  {71'd0, bus.i_rdy}, 73'd2);
    chk("full_i_rdyE", {71'd0, bus.i_rdyE}, 73'd2);
    send_frame(1'b0, 1, 1, 0);
    chk("ovf_err", {72'd0, bus.ff_err}, 73'd1);
    bus.o_rdy = 2'b01;
    wait_drain("drain_full");
    idle(2);
    chk("drained_i_rdyE", {71'd0, bus.i_rdyE}, 73'd3);
    for (int f = 0; f < 5; f++) begin
      wait_rdy(1'b0);
      send_frame(1'b0, lens[f], lens[f], 1);
    end
    wait_drain("drain_wrap");

    // Stray non-header word, then reset clears the error
    do_reset();
    idle(1);
    drive_word(1'b0, rand_word());
    idle(2);
    chk("stray_err",   {72'd0, bus.ff_err}, 73'd1);
    chk("stray_empty", {71'd0, bus.i_rdyE}, 73'd3);
    do_reset();
    chk("clr_err",   {72'd0, bus.ff_err}, 73'd0);
    chk("clr_i_rdyE", {71'd0, bus.i_rdyE}, 73'd3);

    // Gap mid-frame closes the partial frame
    bus.o_rdy = 2'b11;
    send_frame(1'b1, 4, 2, 1);
    idle(2);
    chk("gap_err", {72'd0, bus.ff_err}, 73'd1);
    wait_drain("drain_gap");
    do_reset();

    // A new header inside a frame is dropped; the partial frame is kept
    send_frame(1'b0, 4, 2, 1);
    drive_word(1'b1, header(1'b0, 3));
    drive_word(1'b0, rand_word());
    drive_word(1'b0, rand_word());
    idle(1);
    chk("sof_err", {72'd0, bus.ff_err}, 73'd1);
    wait_drain("drain_sof");
    do_reset();

    // Reset on the third word of a 16-word output frame
    bus.o_rdy = 2'b00;
    send_frame(1'b0, 16, 16, 1);
    bus.o_rdy = 2'b01;
    idle(1);
    chk("r28_sof", {72'd0, bus.o_sof}, 73'd1);
    idle(2);
    do_reset();
    chk("r28_stb",  {72'd0, bus.o_stb}, 73'd0);
    chk("r28_data", {1'b0, bus.o_data}, 73'd0);
    bus.o_rdy = 2'b11;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      seen |= bus.o_stb;
      idle(1);
    end
    chk("r28_quiet", {72'd0, seen}, 73'd0);
    send_frame(1'b1, 3, 3, 1);
    wait_drain("drain_r28");

    // Random frames with random consumer readiness
    rand_mode = 1;
    for (int f = 0; f < 150; f++) begin
      logic c;
      int   l;
      c = 1'($urandom_range(0, 1));
      l = int'($urandom_range(1, 16));
      wait_rdy(c);
      send_frame(c, l, l, 1);
      idle(int'($urandom_range(0, 3)));
    end
    rand_mode = 0;
    bus.o_rdy = 2'b11;
    wait_drain("drain_rand");
    chk("rand_no_err", {72'd0, bus.ff_err}, 73'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/rbus_frame_buffer.md
RBUS_FRAME_BUFFER -- requirements
Module: rbus_frame_buffer

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 32, giving the words per class FIFO; DEPTH SHALL be a power of two and at least 32.
REQ-002 The block SHALL have a parameter MAXLEN, default 16, giving the maximum frame length in words.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- i_stb  in  1  input word valid.
- i_sof  in  1  first word (header) of a frame.
- i_data  in  72  input word.
- i_rdy  out  2  bit c: class-c FIFO has at least MAXLEN free words.
- i_rdyE  out  2  bit c: class-c FIFO is completely empty.
- o_stb  out  1  output word valid.
- o_sof  out  1  output header word.
- o_data  out  72  output word.
- o_rdy  in  2  bit c: the consumer accepts a new class-c frame.
- o_rdyE  in  2  bit c: the consumer's class-c path is empty.
- ff_err  out  1  sticky protocol/overflow error.

Function
REQ-004 Frame format: the header word carries the class in data[71] and the length in data[70:67]+1 (1..16 words), and the words of a frame SHALL arrive on consecutive i_stb cycles.
REQ-005 Class-c words SHALL be written into FIFO c, including the header.
REQ-006 Write tracking:
- A word-remaining counter loads from the header and decrements on each i_stb.
- The complete-frame count of class c increments in the cycle its last word is written.
REQ-007 i_rdy[c] and i_rdyE[c] SHALL be registered and reflect the occupancy after the current cycle's write and read.
REQ-008 The block SHALL be store-and-forward: no word of a frame is output before its last word is stored.
REQ-009 The output FSM SHALL have states IDLE and SEND.
REQ-010 In IDLE, class 1 is eligible when its complete-frame count > 0 and o_rdy[1]=1; class 0 is eligible under the same rule using its own count and o_rdy[0].
REQ-011 In IDLE, class 1 SHALL have strict priority over class 0; the selected class SHALL be latched and the FSM SHALL go to SEND.
REQ-012 In SEND, the block SHALL output one word per cycle with o_stb=1, without gaps and without rechecking o_rdy.
REQ-013 o_sof SHALL be 1 only on the header word.
REQ-014 After the last word, the FSM SHALL decrement that class's complete-frame count and return to IDLE, with at least one idle cycle between output frames.
REQ-015 Latency: if a frame's last word is written in cycle t with the class idle and eligible, o_sof SHALL appear in cycle t+2.
REQ-016 o_stb, o_sof and o_data SHALL be registered outputs; o_data SHALL hold its last value when o_stb=0.
REQ-017 Simultaneous write and read on the same FIFO in one cycle SHALL be supported, with occupancy unchanged.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH.
REQ-019 ff_err SHALL set, and stay set until reset, on any of these errors:
- a write to a full FIFO, where the word is dropped;
- i_stb with i_sof=0 outside a frame, where the word is dropped;
- i_sof=1 while words remain in the current frame, where the new frame is dropped and the partial frame is still counted complete;
- a gap in i_stb mid-frame, where the frame is closed as complete and the next word is treated as a new input.
REQ-020 o_rdyE SHALL be accepted but SHALL NOT affect behaviour.

Reset
REQ-021 While rst=0 at a rising edge:
- both FIFOs and all counters SHALL clear and the FSM SHALL enter IDLE;
- o_stb=0, o_sof=0, o_data=0, ff_err=0, i_rdy=2'b11, i_rdyE=2'b11.
REQ-022 Asserting reset mid-frame on either side SHALL discard every partial and stored frame; no word SHALL be output after reset deasserts until a new complete frame is written.

Verification
REQ-023 Single frame: a class-0 frame of 4 words, with the header data[70:67]=3 and o_rdy=2'b01 -> 4 words out starting at t+2, o_sof on the first word only, data identical.
REQ-024 Priority: complete class-0 and class-1 frames both stored, then o_rdy=2'b11 -> the class-1 frame is output first, then the class-0 frame after one idle cycle.
REQ-025 Backpressure: a stored class-0 frame with o_rdy=2'b00 held for 20 cycles -> o_stb stays 0; raising o_rdy[0]=1 -> output starts 1 cycle later.
REQ-026 Full/wrap: with DEPTH=32, write two 16-word class-0 frames -> i_rdy[0]=0; one more word -> ff_err=1; drain, then write 5 more frames -> all data correct across pointer wrap.
REQ-027 Protocol errors: i_stb with i_sof=0 while idle -> ff_err=1 and nothing stored; then rst=0 for one cycle -> ff_err=0, i_rdyE=2'b11.
REQ-028 Reset mid-output: assert rst=0 during the 3rd word of a 16-word output frame -> o_stb=0 the next cycle, and nothing is output until a new frame is written.
